lsu_bus_master: RTL and testbench

//  Initiator side of dualport_bus: turns one load/store request from the CPU MEM stage into bus rd/wr transactions.

---
 rtl/lsu_bus_master_pkg.sv | 41 ++++
 rtl/lsu_bus_master_if.sv | 24 ++
 rtl/lsu_bus_master_align.sv | 45 ++++
 rtl/lsu_bus_master.sv | 172 +++++++++++++++++
 tb/tb_lsu_bus_master.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_bus_master_pkg.sv
// Shared definitions for the load/store bus master: funct3 encodings, FSM state type
// and the access legality helpers.
package lsu_bus_master_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StResp
  } lsu_state_t;

  // Halfwords need bit 0 clear, words need both low bits clear.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    case (funct3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Reserved encodings are always illegal; unsigned variants only exist for loads.
  function automatic logic is_illegal(input logic [2:0] funct3, input logic we);
    logic ill;
    case (funct3)
      F3_B, F3_H, F3_W: ill = 1'b0;
      F3_BU, F3_HU:     ill = we;
      default:          ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Dual-port memory bus: independent read and write request/grant channels.
interface lsu_bus_master_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [31:0]       rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic              wr_gnt;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_be, wr_data,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_be, wr_data,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/lsu_bus_master_align.sv
// Byte-lane logic for RV32 sub-word accesses: store byte-enables and lane replication,
// load lane extraction with sign or zero extension. Purely combinational.
module lsu_bus_master_align
  import lsu_bus_master_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] st_lanes_o,
  output logic [31:0] ld_ext_o
);

  logic [31:0] ld_shift;

  // Steer store data onto its lanes and pull load data down from its lanes.
  always_comb begin
    ld_shift   = ld_data_i >> {off_i, 3'b000};
    be_o       = 4'b0000;
    st_lanes_o = 32'h0;
    ld_ext_o   = 32'h0;
    case (funct3_i)
      F3_B: begin
        be_o       = 4'b0001 << off_i;
        st_lanes_o = {4{st_data_i[7:0]}};
        ld_ext_o   = {{24{ld_shift[7]}}, ld_shift[7:0]};
      end
      F3_H: begin
        be_o       = 4'b0011 << off_i;
        st_lanes_o = {2{st_data_i[15:0]}};
        ld_ext_o   = {{16{ld_shift[15]}}, ld_shift[15:0]};
      end
      F3_W: begin
        be_o       = 4'b1111;
        st_lanes_o = st_data_i;
        ld_ext_o   = ld_shift;
      end
      F3_BU:   ld_ext_o = {24'h0, ld_shift[7:0]};
      F3_HU:   ld_ext_o = {16'h0, ld_shift[15:0]};
      default: ld_ext_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store unit bus initiator: takes one MEM-stage request at a time, runs it as a
// single read or write on the dual-port bus and returns a one-cycle response.
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  lsu_bus_master_if.master  mem_master
);

  localparam int unsigned CntW = $clog2(RD_LAT + 1);

  lsu_state_t        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]        wr_be_q, wr_be_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              idle;
  logic [2:0]        al_f3;
  logic [1:0]        al_off;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;
  logic [ADDR_W-1:0] word_addr;

  // In IDLE the lane logic steers the incoming store; afterwards it decodes the held load.
  assign idle      = (state_q == StIdle);
  assign al_f3     = idle ? req_funct3 : f3_q;
  assign al_off    = idle ? req_addr[1:0] : off_q;
  assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

  lsu_bus_master_align u_align (
    .funct3_i   (al_f3),
    .off_i      (al_off),
    .st_data_i  (req_wdata),
    .ld_data_i  (mem_master.rd_data),
    .be_o       (al_be),
    .st_lanes_o (al_wdata),
    .ld_ext_o   (al_rdata)
  );

  // Next-state, bus request and response decode.
  always_comb begin
    state_d      = state_q;
    f3_d         = f3_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    rd_req_d     = rd_req_q;
    rd_addr_d    = rd_addr_q;
    wr_req_d     = wr_req_q;
    wr_addr_d    = wr_addr_q;
    wr_be_d      = wr_be_q;
    wr_data_d    = wr_data_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          f3_d  = req_funct3;
          off_d = req_addr[1:0];
          if (is_illegal(req_funct3, req_we) || is_misaligned(req_funct3, req_addr[1:0])) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we) begin
            state_d   = StWrReq;
            wr_req_d  = 1'b1;
            wr_addr_d = word_addr;
            wr_be_d   = al_be;
            wr_data_d = al_wdata;
          end else begin
            state_d   = StRdReq;
            rd_req_d  = 1'b1;
            rd_addr_d = word_addr;
          end
        end
      end
      StRdReq: begin
        if (mem_master.rd_gnt) begin
          rd_req_d = 1'b0;
          cnt_d    = CntW'(RD_LAT);
          state_d  = StRdWait;
        end
      end
      StRdWait: begin
        cnt_d = cnt_q - CntW'(1);
        // Last wait cycle is the one in which the slave presents read data.
        if (cnt_q == CntW'(1)) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_rdata_d = al_rdata;
        end
      end
      StWrReq: begin
        if (mem_master.wr_gnt) begin
          wr_req_d     = 1'b0;
          state_d      = StResp;
          resp_valid_d = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      f3_q         <= F3_B;
      off_q        <= 2'b00;
      cnt_q        <= '0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_be_q      <= 4'b0000;
      wr_data_q    <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      wr_be_q      <= wr_be_d;
      wr_data_q    <= wr_data_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready          = idle;
  assign resp_valid         = resp_valid_q;
  assign resp_rdata         = resp_rdata_q;
  assign resp_err           = resp_err_q;
  assign mem_master.rd_req  = rd_req_q;
  assign mem_master.rd_addr = rd_addr_q;
  assign mem_master.wr_req  = wr_req_q;
  assign mem_master.wr_addr = wr_addr_q;
  assign mem_master.wr_be   = wr_be_q;
  assign mem_master.wr_data = wr_data_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: word-addressed RAM slave with programmable grant delay,
// a vector table of loads/stores with hand-computed results, and directed sequences
// for a stalled grant and a reset during a load.
module tb_lsu_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  lsu_bus_master_if #(.ADDR_W(32)) bus ();

  lsu_bus_master #(.ADDR_W(32), .RD_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_master (bus)
  );

  always #5 clk = ~clk;

  // RAM slave: grant after gnt_delay stalled cycles, read data one cycle after the grant.
  int          gnt_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] mem [64] = '{default: 32'h0};

  assign bus.rd_gnt = bus.rd_req && (wait_cnt >= gnt_delay);
  assign bus.wr_gnt = bus.wr_req && (wait_cnt >= gnt_delay);

  always @(posedge clk) begin
    if ((bus.rd_req && !bus.rd_gnt) || (bus.wr_req && !bus.wr_gnt)) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (bus.rd_req && bus.rd_gnt) bus.rd_data <= mem[bus.rd_addr[7:2]];
    if (bus.wr_req && bus.wr_gnt) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wr_be[b]) mem[bus.wr_addr[7:2]][8*b +: 8] <= bus.wr_data[8*b +: 8];
      end
    end
  end

  // Bus activity monitor.
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  int          both_cyc = 0;
  logic [3:0]  last_be = 4'h0;
  logic [31:0] last_wd = 32'h0;

  always @(negedge clk) begin
    if (bus.rd_req) rd_cyc <= rd_cyc + 1;
    if (bus.wr_req) begin
      wr_cyc  <= wr_cyc + 1;
      last_be <= bus.wr_be;
      last_wd <= bus.wr_data;
    end
    if (bus.rd_req && bus.wr_req) both_cyc <= both_cyc + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request; lat is the cycle of resp_valid counting the accept cycle as 0.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output logic [31:0] rdata, output logic err);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat   = -1;
    rdata = 32'h0;
    err   = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat   = c;
        rdata = resp_rdata;
        err   = resp_err;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  be;
    logic [31:0] wd;
  } vec_t;

  localparam int NV = 21;
  vec_t vec [NV];

  initial begin
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          bus0;
    int          wr0;
    int          seen;

    vec[0]  = '{"sw_10",      1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0,        2, 4'hF, 32'hDEADBEEF};
    vec[1]  = '{"lw_10",      0, 3'b010, 32'h10, 32'h0,        0, 32'hDEADBEEF, 3, 4'h0, 32'h0};
    vec[2]  = '{"sw_10_clr",  1, 3'b010, 32'h10, 32'h0,        0, 32'h0,        2, 4'hF, 32'h0};
    vec[3]  = '{"sb_13",      1, 3'b000, 32'h13, 32'h00000080, 0, 32'h0,        2, 4'h8, 32'h80808080};
    vec[4]  = '{"lb_13",      0, 3'b000, 32'h13, 32'h0,        0, 32'hFFFFFF80, 3, 4'h0, 32'h0};
    vec[5]  = '{"lbu_13",     0, 3'b100, 32'h13, 32'h0,        0, 32'h00000080, 3, 4'h0, 32'h0};
    vec[6]  = '{"sb_11",      1, 3'b000, 32'h11, 32'hAAAA557F, 0, 32'h0,        2, 4'h2, 32'h7F7F7F7F};
    vec[7]  = '{"lb_11",      0, 3'b000, 32'h11, 32'h0,        0, 32'h0000007F, 3, 4'h0, 32'h0};
    vec[8]  = '{"lw_10_mix",  0, 3'b010, 32'h10, 32'h0,        0, 32'h80007F00, 3, 4'h0, 32'h0};
    vec[9]  = '{"sh_22",      1, 3'b001, 32'h22, 32'h12348001, 0, 32'h0,        2, 4'hC, 32'h80018001};
    vec[10] = '{"lh_22",      0, 3'b001, 32'h22, 32'h0,        0, 32'hFFFF8001, 3, 4'h0, 32'h0};
    vec[11] = '{"lhu_22",     0, 3'b101, 32'h22, 32'h0,        0, 32'h00008001, 3, 4'h0, 32'h0};
    vec[12] = '{"lw_20",      0, 3'b010, 32'h20, 32'h0,        0, 32'h80010000, 3, 4'h0, 32'h0};
    vec[13] = '{"lbu_23",     0, 3'b100, 32'h23, 32'h0,        0, 32'h00000080, 3, 4'h0, 32'h0};
    vec[14] = '{"lb_22",      0, 3'b000, 32'h22, 32'h0,        0, 32'h00000001, 3, 4'h0, 32'h0};
    vec[15] = '{"lh_20",      0, 3'b001, 32'h20, 32'h0,        0, 32'h00000000, 3, 4'h0, 32'h0};
    vec[16] = '{"lw_06_mis",  0, 3'b010, 32'h06, 32'h0,        1, 32'h0,        1, 4'h0, 32'h0};
    vec[17] = '{"sh_03_mis",  1, 3'b001, 32'h03, 32'h1234,     1, 32'h0,        1, 4'h0, 32'h0};
    vec[18] = '{"ld_f3_011",  0, 3'b011, 32'h10, 32'h0,        1, 32'h0,        1, 4'h0, 32'h0};
    vec[19] = '{"st_f3_100",  1, 3'b100, 32'h10, 32'h55,       1, 32'h0,        1, 4'h0, 32'h0};
    vec[20] = '{"lh_11_mis",  0, 3'b001, 32'h11, 32'h0,        1, 32'h0,        1, 4'h0, 32'h0};

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_rd_req", 32'(bus.rd_req), 32'h0);
    chk("rst_wr_req", 32'(bus.wr_req), 32'h0);
    chk("rst_rd_addr", bus.rd_addr, 32'h0);
    chk("rst_wr_addr", bus.wr_addr, 32'h0);
    chk("rst_wr_be", 32'(bus.wr_be), 32'h0);
    chk("rst_wr_data", bus.wr_data, 32'h0);
    rst = 1'b0;

    // Table of accesses.
    for (int i = 0; i < NV; i++) begin
      bus0 = rd_cyc + wr_cyc;
      run_req(vec[i].we, vec[i].f3, vec[i].addr, vec[i].wdata, lat, rdata, err);
      chk({vec[i].name, "_lat"}, 32'(lat), 32'(vec[i].lat));
      chk({vec[i].name, "_err"}, 32'(err), 32'(vec[i].err));
      chk({vec[i].name, "_rdata"}, rdata, vec[i].rdata);
      if (vec[i].we && !vec[i].err) begin
        chk({vec[i].name, "_wr_be"}, 32'(last_be), 32'(vec[i].be));
        chk({vec[i].name, "_wr_data"}, last_wd, vec[i].wd);
      end
      if (vec[i].err) chk({vec[i].name, "_no_bus"}, 32'(rd_cyc + wr_cyc - bus0), 32'h0);
      @(negedge clk);
      chk({vec[i].name, "_pulse"}, 32'(resp_valid), 32'h0);
      chk({vec[i].name, "_ready"}, 32'(req_ready), 32'h1);
    end

    // Stalled read grant; a store request offered meanwhile must be ignored.
    gnt_delay = 5;
    wr0 = wr_cyc;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    @(posedge clk);
    #1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'h11111111;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("stall_rd_req", 32'(bus.rd_req), 32'h1);
      chk("stall_rd_gnt", 32'(bus.rd_gnt), 32'h0);
      chk("stall_rd_addr", bus.rd_addr, 32'h10);
      chk("stall_ready", 32'(req_ready), 32'h0);
    end
    @(negedge clk);
    chk("stall_gnt_cycle6", 32'(bus.rd_gnt), 32'h1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("stall_no_resp_c7", 32'(resp_valid), 32'h0);
    @(negedge clk);
    chk("stall_resp_c8", 32'(resp_valid), 32'h1);
    chk("stall_rdata", resp_rdata, 32'h80007F00);
    chk("stall_err", 32'(resp_err), 32'h0);
    @(negedge clk);
    chk("stall_store_ignored", 32'(wr_cyc - wr0), 32'h0);
    gnt_delay = 0;

    // Reset in the cycle after a load is granted.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h1);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("mid_rst_rd_req", 32'(bus.rd_req), 32'h0);
    chk("mid_rst_rd_addr", bus.rd_addr, 32'h0);
    chk("mid_rst_wr_req", 32'(bus.wr_req), 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("mid_rst_no_resp", 32'(seen), 32'h0);

    run_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rdata, err);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_rdata", rdata, 32'h80010000);
    chk("post_rst_err", 32'(err), 32'h0);

    @(negedge clk);
    chk("rd_wr_overlap", 32'(both_cyc), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
